mshr_file: RTL and testbench

//  Miss Status Holding Register file: the responder side of the LSQ miss interface.
//  - On a cache miss it allocates an entry or merges into an existing entry for the same line.
//  - It returns the entry index that the LSQ stores as mshr_wr_idx.
//  - It issues one line fill per entry to memory and accepts the response.
//  - It then drives a one-cycle fill plus mshr_fin/mshr_fin_idx broadcast that wakes the waiting LSQ entries.

---
 rtl/mshr_file_pkg.sv | 13 +
 rtl/mshr_prio_enc.sv | 20 ++
 rtl/mshr_file.sv | 163 ++++++++++++++++
 tb/tb_mshr_file.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mshr_file_pkg.sv
// MSHR entry state encodings shared by the miss path (MSHR file, LSQ, cache controller).
// Pure definitions: no latency, no flow control.
package mshr_file_pkg;

    localparam logic [1:0] MSHR_INVALID = 2'd0;
    localparam logic [1:0] MSHR_PENDING = 2'd1;
    localparam logic [1:0] MSHR_ISSUED  = 2'd2;
    localparam logic [1:0] MSHR_FILL    = 2'd3;

    localparam int MSHR_OFFSET_W = 6;
    localparam int MSHR_IDX_W    = 3;

endpackage

// File: rtl/mshr_prio_enc.sv
// Lowest-set-bit encoder: found flag plus index of the lowest asserted request.
// Combinational, zero latency; no flow control.
module mshr_prio_enc #(
    parameter int N     = 8,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req_i,
    output logic             found_o,
    output logic [IDX_W-1:0] idx_o
);

    always_comb begin
        found_o = |req_i;
        idx_o   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[i]) idx_o = IDX_W'(i);
        end
    end

endmodule

// File: rtl/mshr_file.sv
// MSHR file: allocate/merge misses per line, issue one fill per entry, broadcast fill + fin.
// Alloc decision comb, req >=1 cycle after alloc and held while mem_req_ready=0; responses always accepted.
module mshr_file
    import mshr_file_pkg::*;
#(
    parameter int N_ENTRIES = 8,
    parameter int ADDR_W    = 32,
    parameter int OFFSET_W  = 6,
    parameter int LINE_W    = 512,
    localparam int IDX_W    = $clog2(N_ENTRIES)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alloc_req,
    input  logic [ADDR_W-1:0] alloc_addr,
    output logic              alloc_ack,
    output logic              alloc_merge,
    output logic [IDX_W-1:0]  alloc_idx,
    output logic              mshr_full,
    output logic              mem_req_valid,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic [IDX_W-1:0]  mem_req_tag,
    input  logic              mem_req_ready,
    input  logic              mem_resp_valid,
    input  logic [IDX_W-1:0]  mem_resp_tag,
    input  logic [LINE_W-1:0] mem_resp_data,
    output logic              fill_valid,
    output logic [ADDR_W-1:0] fill_addr,
    output logic [LINE_W-1:0] fill_data,
    output logic              mshr_fin,
    output logic [IDX_W-1:0]  mshr_fin_idx,
    output logic              mshr_err
);

    localparam int LA_W = ADDR_W - OFFSET_W;

    logic [N_ENTRIES-1:0][1:0]      state_all;
    logic [N_ENTRIES-1:0][LA_W-1:0] line_all;
    logic [N_ENTRIES-1:0]           free_vec, pend_vec, match_vec;

    logic [LA_W-1:0]  alloc_line;
    logic             free_found, pend_found, merge_found;
    logic [IDX_W-1:0] free_idx, pend_idx, merge_idx, req_idx;
    logic             alloc_new, issue_fire, resp_ok;

    logic              hold_q, hold_d;
    logic [IDX_W-1:0]  hold_idx_q, hold_idx_d;
    logic              fin_q, fin_d;
    logic [IDX_W-1:0]  fin_idx_q, fin_idx_d;
    logic [LINE_W-1:0] fill_data_q, fill_data_d;
    logic              err_q, err_d;

    logic unused_offset;
    assign unused_offset = ^alloc_addr[OFFSET_W-1:0];
    assign alloc_line    = alloc_addr[ADDR_W-1:OFFSET_W];

    mshr_prio_enc #(.N(N_ENTRIES), .IDX_W(IDX_W)) u_free_enc (
        .req_i   (free_vec),
        .found_o (free_found),
        .idx_o   (free_idx)
    );

    mshr_prio_enc #(.N(N_ENTRIES), .IDX_W(IDX_W)) u_pend_enc (
        .req_i   (pend_vec),
        .found_o (pend_found),
        .idx_o   (pend_idx)
    );

    // FILL entries are excluded from merging so a refetch of the same line gets a fresh entry.
    always_comb begin
        merge_found = |match_vec;
        merge_idx   = '0;
        for (int i = N_ENTRIES - 1; i >= 0; i--) begin
            if (match_vec[i]) merge_idx = IDX_W'(i);
        end
    end

    assign alloc_new   = alloc_req && !merge_found && free_found;
    assign alloc_ack   = alloc_req && (merge_found || free_found);
    assign alloc_merge = alloc_req && merge_found;
    assign alloc_idx   = !alloc_req ? '0 :
                         merge_found ? merge_idx :
                         free_found  ? free_idx  : '0;
    assign mshr_full   = !free_found;

    // A stalled request is pinned so a newly allocated lower-index entry cannot displace it.
    assign req_idx       = hold_q ? hold_idx_q : pend_idx;
    assign mem_req_valid = hold_q || pend_found;
    assign mem_req_tag   = req_idx;
    assign mem_req_addr  = {line_all[req_idx], {OFFSET_W{1'b0}}};
    assign issue_fire    = mem_req_valid && mem_req_ready;

    assign resp_ok = mem_resp_valid && (state_all[mem_resp_tag] == MSHR_ISSUED);

    assign hold_d      = mem_req_valid && !mem_req_ready;
    assign hold_idx_d  = req_idx;
    assign fin_d       = resp_ok;
    assign fin_idx_d   = resp_ok ? mem_resp_tag : fin_idx_q;
    assign fill_data_d = resp_ok ? mem_resp_data : fill_data_q;
    assign err_d       = err_q || (mem_resp_valid && !resp_ok);

    for (genvar i = 0; i < N_ENTRIES; i++) begin : g_entry
        logic [1:0]      st_q, st_d;
        logic [LA_W-1:0] ln_q, ln_d;
        logic            take;

        assign take = alloc_new && (free_idx == IDX_W'(i));

        always_comb begin
            st_d = st_q;
            ln_d = take ? alloc_line : ln_q;
            case (st_q)
                MSHR_INVALID: if (take) st_d = MSHR_PENDING;
                MSHR_PENDING: if (issue_fire && req_idx == IDX_W'(i)) st_d = MSHR_ISSUED;
                MSHR_ISSUED:  if (resp_ok && mem_resp_tag == IDX_W'(i)) st_d = MSHR_FILL;
                MSHR_FILL:    st_d = MSHR_INVALID;
                default:      st_d = MSHR_INVALID;
            endcase
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                st_q <= MSHR_INVALID;
                ln_q <= '0;
            end else begin
                st_q <= st_d;
                ln_q <= ln_d;
            end
        end

        assign state_all[i] = st_q;
        assign line_all[i]  = ln_q;
        assign free_vec[i]  = (st_q == MSHR_INVALID);
        assign pend_vec[i]  = (st_q == MSHR_PENDING);
        assign match_vec[i] = ((st_q == MSHR_PENDING) || (st_q == MSHR_ISSUED)) && (ln_q == alloc_line);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_q      <= 1'b0;
            hold_idx_q  <= '0;
            fin_q       <= 1'b0;
            fin_idx_q   <= '0;
            fill_data_q <= '0;
            err_q       <= 1'b0;
        end else begin
            hold_q      <= hold_d;
            hold_idx_q  <= hold_idx_d;
            fin_q       <= fin_d;
            fin_idx_q   <= fin_idx_d;
            fill_data_q <= fill_data_d;
            err_q       <= err_d;
        end
    end

    assign fill_valid   = fin_q;
    assign mshr_fin     = fin_q;
    assign mshr_fin_idx = fin_idx_q;
    assign fill_addr    = {line_all[fin_idx_q], {OFFSET_W{1'b0}}};
    assign fill_data    = fill_data_q;
    assign mshr_err     = err_q;

endmodule

// File: tb/tb_mshr_file.sv
// Bench for mshr_file: directed alloc/issue/response sequences with request and fin scoreboards.
module tb_mshr_file;

    localparam int N  = 8;
    localparam int AW = 32;
    localparam int OW = 6;
    localparam int LW = 512;
    localparam int IW = 3;

    logic          clk, rst;
    logic          alloc_req, alloc_ack, alloc_merge, mshr_full;
    logic [AW-1:0] alloc_addr;
    logic [IW-1:0] alloc_idx;
    logic          mem_req_valid, mem_req_ready;
    logic [AW-1:0] mem_req_addr;
    logic [IW-1:0] mem_req_tag;
    logic          mem_resp_valid;
    logic [IW-1:0] mem_resp_tag;
    logic [LW-1:0] mem_resp_data;
    logic          fill_valid, mshr_fin, mshr_err;
    logic [AW-1:0] fill_addr;
    logic [LW-1:0] fill_data;
    logic [IW-1:0] mshr_fin_idx;

    mshr_file #(.N_ENTRIES(N), .ADDR_W(AW), .OFFSET_W(OW), .LINE_W(LW)) dut (
        .clk            (clk),
        .rst            (rst),
        .alloc_req      (alloc_req),
        .alloc_addr     (alloc_addr),
        .alloc_ack      (alloc_ack),
        .alloc_merge    (alloc_merge),
        .alloc_idx      (alloc_idx),
        .mshr_full      (mshr_full),
        .mem_req_valid  (mem_req_valid),
        .mem_req_addr   (mem_req_addr),
        .mem_req_tag    (mem_req_tag),
        .mem_req_ready  (mem_req_ready),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_tag   (mem_resp_tag),
        .mem_resp_data  (mem_resp_data),
        .fill_valid     (fill_valid),
        .fill_addr      (fill_addr),
        .fill_data      (fill_data),
        .mshr_fin       (mshr_fin),
        .mshr_fin_idx   (mshr_fin_idx),
        .mshr_err       (mshr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [IW-1:0] tag;
    } req_t;

    typedef struct {
        logic [IW-1:0] idx;
        logic [AW-1:0] addr;
        logic [LW-1:0] data;
    } fin_t;

    req_t          req_q[$];
    fin_t          fin_q[$];
    req_t          mon_r;
    fin_t          mon_f;
    logic [AW-1:0] line_addr [N];
    int            n_checks = 0;
    int            n_pass   = 0;
    int            fin_cnt  = 0;
    int            fc0;

    task automatic check_eq(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    always @(negedge clk) begin
        if (rst) begin
            if (mem_req_valid && mem_req_ready) begin
                if (req_q.size() == 0) check_eq("req_unexpected", mem_req_valid, 1'b0);
                else begin
                    mon_r = req_q.pop_front();
                    check_eq("req_addr", mem_req_addr, mon_r.addr);
                    check_eq("req_tag", mem_req_tag, mon_r.tag);
                end
            end
            if (mshr_fin) begin
                fin_cnt++;
                if (fin_q.size() == 0) check_eq("fin_unexpected", mshr_fin, 1'b0);
                else begin
                    mon_f = fin_q.pop_front();
                    check_eq("fill_valid", fill_valid, 1'b1);
                    check_eq("fin_idx", mshr_fin_idx, mon_f.idx);
                    check_eq("fill_addr", fill_addr, mon_f.addr);
                    check_eq("fill_data", fill_data, mon_f.data);
                end
            end
        end
    end

    task automatic do_alloc(input logic [AW-1:0] a, input logic e_ack, input logic e_merge,
                            input logic [IW-1:0] e_idx);
        req_t r;
        alloc_req  = 1'b1;
        alloc_addr = a;
        @(negedge clk);
        check_eq("alloc_ack", alloc_ack, e_ack);
        check_eq("alloc_merge", alloc_merge, e_merge);
        check_eq("alloc_idx", alloc_idx, e_idx);
        if (e_ack && !e_merge) begin
            line_addr[e_idx] = {a[AW-1:OW], {OW{1'b0}}};
            r.addr = line_addr[e_idx];
            r.tag  = e_idx;
            req_q.push_back(r);
        end
        @(posedge clk); #1;
        alloc_req = 1'b0;
    endtask

    task automatic do_resp(input logic [IW-1:0] t, input logic issued);
        logic [LW-1:0] d;
        fin_t f;
        for (int k = 0; k < LW / 32; k++) d[32*k +: 32] = $urandom();
        mem_resp_valid = 1'b1;
        mem_resp_tag   = t;
        mem_resp_data  = d;
        if (issued) begin
            f.idx  = t;
            f.addr = line_addr[t];
            f.data = d;
            fin_q.push_back(f);
        end
        @(posedge clk); #1;
        mem_resp_valid = 1'b0;
        mem_resp_data  = ~d;
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int k = 0;
        while ((req_q.size() != 0 || fin_q.size() != 0) && k < budget) begin
            @(posedge clk); #1;
            k++;
        end
        check_eq(tag, (req_q.size() == 0) && (fin_q.size() == 0), 1'b1);
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; alloc_req = 1'b0; alloc_addr = '0; mem_req_ready = 1'b0;
        mem_resp_valid = 1'b0; mem_resp_tag = '0; mem_resp_data = '0;
        for (int i = 0; i < N; i++) line_addr[i] = '0;
        #1 rst = 1'b0;
        #2;
        check_eq("rst_req_valid", mem_req_valid, 1'b0);
        check_eq("rst_fill_valid", fill_valid, 1'b0);
        check_eq("rst_fin", mshr_fin, 1'b0);
        check_eq("rst_err", mshr_err, 1'b0);
        check_eq("rst_full", mshr_full, 1'b0);
        check_eq("rst_fill_data", fill_data, '0);
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;

        // Allocation, 1-cycle presentation latency, then issue.
        do_alloc(32'h0000_1000, 1'b1, 1'b0, 3'd0);
        @(negedge clk);
        check_eq("t1_req_valid", mem_req_valid, 1'b1);
        check_eq("t1_req_tag", mem_req_tag, 3'd0);
        check_eq("t1_req_addr", mem_req_addr, 32'h0000_1000);
        @(posedge clk); #1;
        mem_req_ready = 1'b1;
        wait_drain("t1_issue", 10);

        // Merge into the issued entry produces no second request.
        do_alloc(32'h0000_1010, 1'b1, 1'b1, 3'd0);
        @(negedge clk);
        check_eq("t2_no_req", mem_req_valid, 1'b0);
        @(posedge clk); #1;

        // Fill cycle: entry 0 busy during fin, free the cycle after.
        fc0 = fin_cnt;
        do_resp(3'd0, 1'b1);
        do_alloc(32'h0000_2000, 1'b1, 1'b0, 3'd1);
        do_alloc(32'h0000_3000, 1'b1, 1'b0, 3'd0);
        wait_drain("t3_drain", 20);
        check_eq("t3_fin_once", fin_cnt - fc0, 1);
        do_resp(3'd1, 1'b1);
        do_resp(3'd0, 1'b1);
        wait_drain("t3_fins", 10);
        check_eq("t3_fin_b2b", fin_cnt - fc0, 3);
        check_eq("t3_no_err", mshr_err, 1'b0);

        // Fill all entries, reject a new line, merge while full.
        for (int k = 0; k < N; k++) do_alloc(32'h0001_0000 + 32'(k * 64), 1'b1, 1'b0, 3'(k));
        @(negedge clk);
        check_eq("t4_full", mshr_full, 1'b1);
        @(posedge clk); #1;
        do_alloc(32'h0002_0000, 1'b0, 1'b0, 3'd0);
        do_alloc(32'h0001_00C8, 1'b1, 1'b1, 3'd3);
        wait_drain("t4_issue", 30);
        for (int k = N - 1; k >= 0; k--) do_resp(3'(k), 1'b1);
        wait_drain("t4_fins", 20);
        check_eq("t4_not_full", mshr_full, 1'b0);

        // Stalled request stays on entry 2 with entries 2 and 5 pending.
        for (int k = 0; k < 5; k++) do_alloc(32'h0004_0000 + 32'(k * 64), 1'b1, 1'b0, 3'(k));
        wait_drain("t5_issue", 20);
        do_resp(3'd2, 1'b1);
        wait_drain("t5_fin2", 10);
        mem_req_ready = 1'b0;
        do_alloc(32'h0005_0000, 1'b1, 1'b0, 3'd2);
        do_alloc(32'h0005_0040, 1'b1, 1'b0, 3'd5);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check_eq("t5_hold_valid", mem_req_valid, 1'b1);
            check_eq("t5_hold_tag", mem_req_tag, 3'd2);
            check_eq("t5_hold_addr", mem_req_addr, 32'h0005_0000);
            @(posedge clk); #1;
        end
        mem_req_ready = 1'b1;
        wait_drain("t5_release", 10);
        for (int k = 0; k < 6; k++) do_resp(3'(k), 1'b1);
        wait_drain("t5_fins", 20);

        // Response to a non-issued tag, then reset mid-flight.
        fc0 = fin_cnt;
        do_resp(3'd4, 1'b0);
        @(negedge clk);
        check_eq("t6_no_fin", mshr_fin, 1'b0);
        check_eq("t6_err", mshr_err, 1'b1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("t6_err_sticky", mshr_err, 1'b1);
        check_eq("t6_fin_count", fin_cnt - fc0, 0);
        @(posedge clk); #1;
        mem_req_ready = 1'b0;
        do_alloc(32'h0006_0000, 1'b1, 1'b0, 3'd0);
        @(negedge clk);
        check_eq("t6_req_pending", mem_req_valid, 1'b1);
        #2 rst = 1'b0;
        #1;
        check_eq("t6_rst_req_valid", mem_req_valid, 1'b0);
        check_eq("t6_rst_req_addr", mem_req_addr, 32'h0);
        check_eq("t6_rst_err", mshr_err, 1'b0);
        check_eq("t6_rst_fill_valid", fill_valid, 1'b0);
        check_eq("t6_rst_fill_data", fill_data, '0);
        check_eq("t6_rst_fill_addr", fill_addr, 32'h0);
        req_q.delete();
        fin_q.delete();
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check_eq("t6_post_err", mshr_err, 1'b0);
        check_eq("t6_post_req", mem_req_valid, 1'b0);
        check_eq("t6_post_full", mshr_full, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
